// File: rtl/rom_bus_pkg.sv
// -----------------------------------------------------------------------------
// rom_bus_pkg
// Shared types and constants for the external ROM/SRAM bus sequencer.
//   state_t        : sequencer FSM states
//   PHASE_RD/WR    : phase-select values (matches the pending "we" bit)
//   STROBE_*       : active-low strobe levels for CE_N/OE_N/WE_N
//   DATA_OE_*      : data bus drive enable levels
//   max3()         : helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package rom_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNES_RD = 3'd1,
      ST_SNES_WR = 3'd2,
      ST_GSU_RD  = 3'd3,
      ST_GSU_WR  = 3'd4,
      ST_RECOVER = 3'd5
   } state_t;

   localparam logic PHASE_RD = 1'b0;
   localparam logic PHASE_WR = 1'b1;

   localparam logic STROBE_IDLE   = 1'b1;
   localparam logic STROBE_ACTIVE = 1'b0;

   localparam logic DATA_OE_IDLE  = 1'b0;
   localparam logic DATA_OE_DRIVE = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/rom_req_slot.sv
// -----------------------------------------------------------------------------
// rom_req_slot
// One-deep holding slot for SNES memory requests.
//   CLK, RST               : clock, synchronous active-high reset
//   i_rd_strobe/i_wr_strobe: one-cycle SNES request pulses (write wins if both)
//   i_addr, i_wdata        : request address / write data
//   i_consume              : sequencer starts the request shown on o_pend_*
//   o_pend_valid/we/addr/wdata : request to serve, including one arriving now
//   o_overrun              : one-cycle pulse, a held request was replaced
// The stored request takes precedence over one arriving in the same cycle;
// when the stored one is consumed the new arrival drops into the slot.
// -----------------------------------------------------------------------------
module rom_req_slot
   import rom_bus_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_rd_strobe,
   input  logic        i_wr_strobe,
   input  logic [23:0] i_addr,
   input  logic [7:0]  i_wdata,
   input  logic        i_consume,
   output logic        o_pend_valid,
   output logic        o_pend_we,
   output logic [23:0] o_pend_addr,
   output logic [7:0]  o_pend_wdata,
   output logic        o_overrun
);

   logic        r_valid;
   logic        r_we;
   logic [23:0] r_addr;
   logic [7:0]  r_wdata;
   logic        r_overrun;
   logic        w_strobe;

   assign w_strobe     = i_rd_strobe | i_wr_strobe;
   assign o_pend_valid = r_valid | w_strobe;
   assign o_pend_we    = r_valid ? r_we    : (i_wr_strobe ? PHASE_WR : PHASE_RD);
   assign o_pend_addr  = r_valid ? r_addr  : i_addr;
   assign o_pend_wdata = r_valid ? r_wdata : i_wdata;
   assign o_overrun    = r_overrun;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_strobe & r_valid & ~i_consume;
         // Load when the arrival is not itself the request being consumed:
         // either the slot is busy (overwrite or refill) or nobody consumes.
         if (w_strobe && (r_valid || !i_consume)) begin
            r_valid <= 1'b1;
            r_we    <= i_wr_strobe;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
         end else if (i_consume) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rom_bus_sequencer.sv
// -----------------------------------------------------------------------------
// rom_bus_sequencer
// Turns SNES and GSU memory requests into timed cycles on the shared external
// ROM/SRAM bus. SNES has fixed priority; one SNES request can wait in a slot.
//   CLK, RST                      : clock, synchronous active-high reset
//   snes_rd_strobe/snes_wr_strobe : SNES request pulses; snes_addr/snes_wdata
//   snes_rdata/snes_rdata_valid   : SNES read return (valid is a pulse)
//   snes_overrun                  : pulse, a waiting SNES request was replaced
//   gsu_req/gsu_we/gsu_addr/gsu_wdata : GSU level request, held until gsu_ack
//   gsu_rdata/gsu_ack             : GSU read data / completion pulse
//   ROM_ADDR, ROM_DATA_OUT, ROM_DATA_OE, ROM_DATA_IN : memory address/data pins
//   ROM_CE_N, ROM_OE_N, ROM_WE_N  : active-low memory strobes
// All pin outputs are registered; a phase counter counts each phase down to 1.
// -----------------------------------------------------------------------------
module rom_bus_sequencer
   import rom_bus_pkg::*;
#(
   parameter int RD_CYCLES      = 5,
   parameter int WR_CYCLES      = 6,
   parameter int RECOVER_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        snes_rd_strobe,
   input  logic        snes_wr_strobe,
   input  logic [23:0] snes_addr,
   input  logic [7:0]  snes_wdata,
   output logic [7:0]  snes_rdata,
   output logic        snes_rdata_valid,
   output logic        snes_overrun,
   input  logic        gsu_req,
   input  logic        gsu_we,
   input  logic [23:0] gsu_addr,
   input  logic [7:0]  gsu_wdata,
   output logic [7:0]  gsu_rdata,
   output logic        gsu_ack,
   output logic [23:0] ROM_ADDR,
   input  logic [7:0]  ROM_DATA_IN,
   output logic [7:0]  ROM_DATA_OUT,
   output logic        ROM_DATA_OE,
   output logic        ROM_CE_N,
   output logic        ROM_OE_N,
   output logic        ROM_WE_N
);

   localparam int CNT_W = $clog2(max3(RD_CYCLES, WR_CYCLES, RECOVER_CYCLES) + 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_RD       = CNT_W'(RD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_WR       = CNT_W'(WR_CYCLES);
   localparam logic [CNT_W-1:0] CNT_REC      = CNT_W'(RECOVER_CYCLES);
   // WE_N is low while the remaining count lies in [2, WR_CYCLES-1]:
   // the first write clock is setup, the last is hold.
   localparam logic [CNT_W-1:0] CNT_WE_FIRST = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_WE_LAST  = CNT_W'(2);
   localparam state_t ST_AFTER = (RECOVER_CYCLES == 0) ? ST_IDLE : ST_RECOVER;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [23:0]      r_rom_addr;
   logic [7:0]       r_rom_data_out;
   logic             r_rom_data_oe;
   logic             r_ce_n;
   logic             r_oe_n;
   logic             r_we_n;
   logic [7:0]       r_snes_rdata;
   logic             r_snes_rdata_valid;
   logic [7:0]       r_gsu_rdata;
   logic             r_gsu_ack;

   logic             w_pend_valid;
   logic             w_pend_we;
   logic [23:0]      w_pend_addr;
   logic [7:0]       w_pend_wdata;
   logic             w_consume;
   logic [CNT_W-1:0] w_cnt_dec;
   logic             w_phase_last;

   assign w_consume    = (r_state == ST_IDLE) && w_pend_valid;
   assign w_cnt_dec    = r_cnt - CNT_ONE;
   assign w_phase_last = (r_cnt == CNT_ONE);

   rom_req_slot u_slot (
      .CLK          (CLK),
      .RST          (RST),
      .i_rd_strobe  (snes_rd_strobe),
      .i_wr_strobe  (snes_wr_strobe),
      .i_addr       (snes_addr),
      .i_wdata      (snes_wdata),
      .i_consume    (w_consume),
      .o_pend_valid (w_pend_valid),
      .o_pend_we    (w_pend_we),
      .o_pend_addr  (w_pend_addr),
      .o_pend_wdata (w_pend_wdata),
      .o_overrun    (snes_overrun)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state            <= ST_IDLE;
         r_cnt              <= '0;
         r_rom_addr         <= '0;
         r_rom_data_out     <= '0;
         r_rom_data_oe      <= DATA_OE_IDLE;
         r_ce_n             <= STROBE_IDLE;
         r_oe_n             <= STROBE_IDLE;
         r_we_n             <= STROBE_IDLE;
         r_snes_rdata       <= '0;
         r_snes_rdata_valid <= 1'b0;
         r_gsu_rdata        <= '0;
         r_gsu_ack          <= 1'b0;
      end else begin
         r_snes_rdata_valid <= 1'b0;
         r_gsu_ack          <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pend_valid) begin
                  r_rom_addr     <= w_pend_addr;
                  r_rom_data_out <= w_pend_wdata;
                  r_ce_n         <= STROBE_ACTIVE;
                  if (w_pend_we == PHASE_WR) begin
                     r_state       <= ST_SNES_WR;
                     r_cnt         <= CNT_WR;
                     r_rom_data_oe <= DATA_OE_DRIVE;
                  end else begin
                     r_state <= ST_SNES_RD;
                     r_cnt   <= CNT_RD;
                     r_oe_n  <= STROBE_ACTIVE;
                  end
               // An ack issued this cycle means the requester has not yet seen
               // it and still holds gsu_req; do not restart the same request.
               end else if (gsu_req && !r_gsu_ack) begin
                  r_rom_addr     <= gsu_addr;
                  r_rom_data_out <= gsu_wdata;
                  r_ce_n         <= STROBE_ACTIVE;
                  if (gsu_we == PHASE_WR) begin
                     r_state       <= ST_GSU_WR;
                     r_cnt         <= CNT_WR;
                     r_rom_data_oe <= DATA_OE_DRIVE;
                  end else begin
                     r_state <= ST_GSU_RD;
                     r_cnt   <= CNT_RD;
                     r_oe_n  <= STROBE_ACTIVE;
                  end
               end
            end
            ST_SNES_RD, ST_GSU_RD: begin
               if (w_phase_last) begin
                  r_state <= ST_AFTER;
                  r_cnt   <= CNT_REC;
                  r_ce_n  <= STROBE_IDLE;
                  r_oe_n  <= STROBE_IDLE;
                  if (r_state == ST_SNES_RD) begin
                     r_snes_rdata       <= ROM_DATA_IN;
                     r_snes_rdata_valid <= 1'b1;
                  end else begin
                     r_gsu_rdata <= ROM_DATA_IN;
                     r_gsu_ack   <= 1'b1;
                  end
               end else begin
                  r_cnt <= w_cnt_dec;
               end
            end
            ST_SNES_WR, ST_GSU_WR: begin
               if (w_phase_last) begin
                  r_state       <= ST_AFTER;
                  r_cnt         <= CNT_REC;
                  r_ce_n        <= STROBE_IDLE;
                  r_we_n        <= STROBE_IDLE;
                  r_rom_data_oe <= DATA_OE_IDLE;
                  if (r_state == ST_GSU_WR) r_gsu_ack <= 1'b1;
               end else begin
                  r_cnt  <= w_cnt_dec;
                  r_we_n <= ((w_cnt_dec >= CNT_WE_LAST) && (w_cnt_dec <= CNT_WE_FIRST))
                            ? STROBE_ACTIVE : STROBE_IDLE;
               end
            end
            ST_RECOVER: begin
               if (w_phase_last) r_state <= ST_IDLE;
               else              r_cnt   <= w_cnt_dec;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ROM_ADDR         = r_rom_addr;
   assign ROM_DATA_OUT     = r_rom_data_out;
   assign ROM_DATA_OE      = r_rom_data_oe;
   assign ROM_CE_N         = r_ce_n;
   assign ROM_OE_N         = r_oe_n;
   assign ROM_WE_N         = r_we_n;
   assign snes_rdata       = r_snes_rdata;
   assign snes_rdata_valid = r_snes_rdata_valid;
   assign gsu_rdata        = r_gsu_rdata;
   assign gsu_ack          = r_gsu_ack;

endmodule

// File: tb/tb_rom_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rom_bus_sequencer
// Directed bench: instance a uses default parameters, instance b has
// RECOVER_CYCLES = 0. Cycle k counts posedges after the request cycle 0;
// outputs are sampled and inputs driven 1 time unit after each posedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rom_bus_sequencer;

   localparam logic [3:0] PINS_IDLE = 4'b1110; // {CE_N, OE_N, WE_N, DATA_OE}
   localparam logic [3:0] PINS_RD   = 4'b0010;
   localparam logic [3:0] PINS_WSH  = 4'b0111; // write setup / hold clock
   localparam logic [3:0] PINS_WE   = 4'b0101; // write strobe clock

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] rom_data_in = 8'h00;

   // instance a stimulus / observation
   logic        a_rd = 0, a_wr = 0, a_req = 0, a_gwe = 0;
   logic [23:0] a_saddr = 0, a_gaddr = 0;
   logic [7:0]  a_swdata = 0, a_gwdata = 0;
   logic [7:0]  a_srdata, a_grdata, a_dout;
   logic        a_valid, a_overrun, a_ack, a_doe, a_ce_n, a_oe_n, a_we_n;
   logic [23:0] a_addr;
   logic [3:0]  a_pins;
   // instance b stimulus / observation
   logic        b_rd = 0, b_wr = 0, b_req = 0, b_gwe = 0;
   logic [23:0] b_saddr = 0, b_gaddr = 0;
   logic [7:0]  b_swdata = 0, b_gwdata = 0;
   logic [7:0]  b_srdata, b_grdata, b_dout;
   logic        b_valid, b_overrun, b_ack, b_doe, b_ce_n, b_oe_n, b_we_n;
   logic [23:0] b_addr;
   logic [3:0]  b_pins;

   int n_cmp = 0;
   int n_err = 0;

   assign a_pins = {a_ce_n, a_oe_n, a_we_n, a_doe};
   assign b_pins = {b_ce_n, b_oe_n, b_we_n, b_doe};

   always #5 clk = ~clk;

   rom_bus_sequencer u_a (
      .CLK(clk), .RST(rst),
      .snes_rd_strobe(a_rd), .snes_wr_strobe(a_wr), .snes_addr(a_saddr), .snes_wdata(a_swdata),
      .snes_rdata(a_srdata), .snes_rdata_valid(a_valid), .snes_overrun(a_overrun),
      .gsu_req(a_req), .gsu_we(a_gwe), .gsu_addr(a_gaddr), .gsu_wdata(a_gwdata),
      .gsu_rdata(a_grdata), .gsu_ack(a_ack),
      .ROM_ADDR(a_addr), .ROM_DATA_IN(rom_data_in), .ROM_DATA_OUT(a_dout), .ROM_DATA_OE(a_doe),
      .ROM_CE_N(a_ce_n), .ROM_OE_N(a_oe_n), .ROM_WE_N(a_we_n)
   );

   rom_bus_sequencer #(.RD_CYCLES(5), .WR_CYCLES(6), .RECOVER_CYCLES(0)) u_b (
      .CLK(clk), .RST(rst),
      .snes_rd_strobe(b_rd), .snes_wr_strobe(b_wr), .snes_addr(b_saddr), .snes_wdata(b_swdata),
      .snes_rdata(b_srdata), .snes_rdata_valid(b_valid), .snes_overrun(b_overrun),
      .gsu_req(b_req), .gsu_we(b_gwe), .gsu_addr(b_gaddr), .gsu_wdata(b_gwdata),
      .gsu_rdata(b_grdata), .gsu_ack(b_ack),
      .ROM_ADDR(b_addr), .ROM_DATA_IN(rom_data_in), .ROM_DATA_OUT(b_dout), .ROM_DATA_OE(b_doe),
      .ROM_CE_N(b_ce_n), .ROM_OE_N(b_oe_n), .ROM_WE_N(b_we_n)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (a_pins !== PINS_IDLE || b_pins !== PINS_IDLE) begin
         n_err++; $display("FAIL reset_pins: a=%b b=%b want %b", a_pins, b_pins, PINS_IDLE);
      end
      n_cmp++;
      if (a_addr !== 24'h0 || a_dout !== 8'h0 || b_addr !== 24'h0 || b_dout !== 8'h0) begin
         n_err++; $display("FAIL reset_bus: a_addr=%h a_dout=%h b_addr=%h b_dout=%h want 0", a_addr, a_dout, b_addr, b_dout);
      end
      n_cmp++;
      if (a_srdata !== 8'h0 || a_grdata !== 8'h0 || b_srdata !== 8'h0 || b_grdata !== 8'h0) begin
         n_err++; $display("FAIL reset_rdata: a=%h/%h b=%h/%h want 0", a_srdata, a_grdata, b_srdata, b_grdata);
      end
      n_cmp++;
      if ({a_valid, a_overrun, a_ack, b_valid, b_overrun, b_ack} !== 6'b0) begin
         n_err++; $display("FAIL reset_pulses: got %b want 000000", {a_valid, a_overrun, a_ack, b_valid, b_overrun, b_ack});
      end
      rst = 1'b0;
      tick();
      $display("txn reset done");
   endtask

   task automatic test_snes_read;
      logic [3:0] exp_pins;
      rom_data_in = 8'h11;
      a_saddr = 24'h400123; a_rd = 1'b1;          // cycle 0
      tick(); a_rd = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         exp_pins = (k <= 5) ? PINS_RD : PINS_IDLE;
         n_cmp++;
         if (a_pins !== exp_pins) begin
            n_err++; $display("FAIL snes_rd_pins cycle %0d: got %b want %b", k, a_pins, exp_pins);
         end
         n_cmp++;
         if ({a_valid, a_ack} !== {(k == 6), 1'b0}) begin
            n_err++; $display("FAIL snes_rd_valid cycle %0d: got %b want %b", k, {a_valid, a_ack}, {(k == 6), 1'b0});
         end
         if (k <= 5) begin
            n_cmp++;
            if (a_addr !== 24'h400123) begin
               n_err++; $display("FAIL snes_rd_addr cycle %0d: got %h want 400123", k, a_addr);
            end
         end
         if (k == 6) begin
            n_cmp++;
            if (a_srdata !== 8'hA5) begin
               n_err++; $display("FAIL snes_rd_data: got %h want a5", a_srdata);
            end
         end
         if (k == 5) rom_data_in = 8'hA5;         // only the last read clock is sampled
         else        rom_data_in = 8'h11;
         tick();
      end
      $display("txn snes_read addr=400123 rdata=%h", a_srdata);
   endtask

   task automatic test_gsu_write;
      logic [3:0] exp_pins;
      a_gaddr = 24'h780010; a_gwdata = 8'h3C; a_gwe = 1'b1; a_req = 1'b1;
      tick();
      for (int k = 1; k <= 9; k++) begin
         if (k == 1 || k == 6)     exp_pins = PINS_WSH;
         else if (k >= 2 && k <= 5) exp_pins = PINS_WE;
         else                      exp_pins = PINS_IDLE;
         n_cmp++;
         if (a_pins !== exp_pins) begin
            n_err++; $display("FAIL gsu_wr_pins cycle %0d: got %b want %b", k, a_pins, exp_pins);
         end
         n_cmp++;
         if (a_ack !== (k == 7)) begin
            n_err++; $display("FAIL gsu_wr_ack cycle %0d: got %b want %b", k, a_ack, (k == 7));
         end
         if (k <= 6) begin
            n_cmp++;
            if (a_addr !== 24'h780010 || a_dout !== 8'h3C) begin
               n_err++; $display("FAIL gsu_wr_bus cycle %0d: got %h/%h want 780010/3c", k, a_addr, a_dout);
            end
         end
         if (k == 7) begin a_req = 1'b0; a_gwe = 1'b0; end
         tick();
      end
      $display("txn gsu_write addr=780010 wdata=3c");
   endtask

   task automatic test_priority;
      logic [3:0] exp_pins;
      int acks;
      acks = 0;
      rom_data_in = 8'h77;
      a_saddr = 24'h012345; a_rd = 1'b1;
      a_gaddr = 24'h0ABCDE; a_gwe = 1'b0; a_req = 1'b1;
      tick(); a_rd = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         exp_pins = ((k >= 1 && k <= 5) || (k >= 8 && k <= 12)) ? PINS_RD : PINS_IDLE;
         n_cmp++;
         if (a_pins !== exp_pins) begin
            n_err++; $display("FAIL prio_pins cycle %0d: got %b want %b", k, a_pins, exp_pins);
         end
         n_cmp++;
         if ({a_valid, a_ack} !== {(k == 6), (k == 13)}) begin
            n_err++; $display("FAIL prio_pulses cycle %0d: got %b want %b", k, {a_valid, a_ack}, {(k == 6), (k == 13)});
         end
         if (k >= 1 && k <= 5) begin
            n_cmp++;
            if (a_addr !== 24'h012345) begin
               n_err++; $display("FAIL prio_snes_addr cycle %0d: got %h want 012345", k, a_addr);
            end
         end
         if (k >= 8 && k <= 12) begin
            n_cmp++;
            if (a_addr !== 24'h0ABCDE) begin
               n_err++; $display("FAIL prio_gsu_addr cycle %0d: got %h want 0abcde", k, a_addr);
            end
         end
         if (k == 6) begin
            n_cmp++;
            if (a_srdata !== 8'h77) begin
               n_err++; $display("FAIL prio_snes_data: got %h want 77", a_srdata);
            end
            rom_data_in = 8'h99;
         end
         if (k == 13) begin
            n_cmp++;
            if (a_grdata !== 8'h99) begin
               n_err++; $display("FAIL prio_gsu_data: got %h want 99", a_grdata);
            end
            a_req = 1'b0;
         end
         if (a_ack) acks++;
         tick();
      end
      n_cmp++;
      if (acks !== 1) begin
         n_err++; $display("FAIL prio_ack_count: got %0d want 1", acks);
      end
      $display("txn snes_read+gsu_read snes=%h gsu=%h acks=%0d", a_srdata, a_grdata, acks);
   endtask

   task automatic test_overrun;
      logic [3:0] exp_pins;
      rom_data_in = 8'hC3;
      a_gaddr = 24'h123456; a_gwe = 1'b0; a_req = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         if (k >= 1) begin
            exp_pins = ((k <= 5) || (k >= 8 && k <= 12)) ? PINS_RD : PINS_IDLE;
            n_cmp++;
            if (a_pins !== exp_pins) begin
               n_err++; $display("FAIL ovr_pins cycle %0d: got %b want %b", k, a_pins, exp_pins);
            end
            n_cmp++;
            if ({a_overrun, a_ack, a_valid} !== {(k == 5), (k == 6), (k == 13)}) begin
               n_err++; $display("FAIL ovr_pulses cycle %0d: got %b want %b", k, {a_overrun, a_ack, a_valid}, {(k == 5), (k == 6), (k == 13)});
            end
            n_cmp++;
            if (a_addr === 24'h0AAAAA) begin
               n_err++; $display("FAIL ovr_stale_addr cycle %0d: got %h want not 0aaaaa", k, a_addr);
            end
            if (k >= 8 && k <= 12) begin
               n_cmp++;
               if (a_addr !== 24'h0BBBBB) begin
                  n_err++; $display("FAIL ovr_addr cycle %0d: got %h want 0bbbbb", k, a_addr);
               end
            end
         end
         a_rd = (k == 2) || (k == 4);
         if (k == 2) a_saddr = 24'h0AAAAA;
         if (k == 4) a_saddr = 24'h0BBBBB;
         if (k == 6) a_req = 1'b0;
         tick();
      end
      $display("txn gsu_read+2x snes_read overrun; served addr=0bbbbb rdata=%h", a_srdata);
   endtask

   task automatic test_reset_mid;
      a_gaddr = 24'h654321; a_gwe = 1'b0; a_req = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         if (k == 3) begin
            n_cmp++;
            if (a_pins !== PINS_RD) begin
               n_err++; $display("FAIL rstmid_active: got %b want %b", a_pins, PINS_RD);
            end
         end
         if (k >= 4) begin
            n_cmp++;
            if (a_pins !== PINS_IDLE || a_ack !== 1'b0) begin
               n_err++; $display("FAIL rstmid_idle cycle %0d: got %b ack=%b want %b ack=0", k, a_pins, a_ack, PINS_IDLE);
            end
         end
         if (k == 4) begin
            n_cmp++;
            if (a_addr !== 24'h0 || a_grdata !== 8'h0 || a_srdata !== 8'h0) begin
               n_err++; $display("FAIL rstmid_regs: got addr=%h grd=%h srd=%h want 0", a_addr, a_grdata, a_srdata);
            end
         end
         rst = (k == 3);
         if (k == 3) a_req = 1'b0;
         tick();
      end
      rom_data_in = 8'h5E;
      a_gaddr = 24'h00ABCD; a_req = 1'b1;
      tick();
      for (int k = 1; k <= 7; k++) begin
         n_cmp++;
         if (a_pins !== ((k <= 5) ? PINS_RD : PINS_IDLE) || a_ack !== (k == 6)) begin
            n_err++; $display("FAIL rstmid_fresh cycle %0d: got %b ack=%b want %b ack=%b", k, a_pins, a_ack, ((k <= 5) ? PINS_RD : PINS_IDLE), (k == 6));
         end
         if (k == 6) begin
            n_cmp++;
            if (a_grdata !== 8'h5E) begin
               n_err++; $display("FAIL rstmid_fresh_data: got %h want 5e", a_grdata);
            end
            a_req = 1'b0;
         end
         tick();
      end
      $display("txn reset_mid_gsu_read then gsu_read rdata=%h", a_grdata);
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_pins;
      b_saddr = 24'h300000; b_rd = 1'b1;
      b_gaddr = 24'h310000; b_gwdata = 8'h42; b_gwe = 1'b1; b_req = 1'b1;
      tick(); b_rd = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (k <= 5)                     exp_pins = PINS_RD;
         else if (k == 7 || k == 12)     exp_pins = PINS_WSH;
         else if (k >= 8 && k <= 11)     exp_pins = PINS_WE;
         else                            exp_pins = PINS_IDLE;
         n_cmp++;
         if (b_pins !== exp_pins) begin
            n_err++; $display("FAIL b2b_pins cycle %0d: got %b want %b", k, b_pins, exp_pins);
         end
         n_cmp++;
         if ({b_valid, b_ack} !== {(k == 6), (k == 13)}) begin
            n_err++; $display("FAIL b2b_pulses cycle %0d: got %b want %b", k, {b_valid, b_ack}, {(k == 6), (k == 13)});
         end
         if (k >= 7 && k <= 12) begin
            n_cmp++;
            if (b_addr !== 24'h310000 || b_dout !== 8'h42) begin
               n_err++; $display("FAIL b2b_bus cycle %0d: got %h/%h want 310000/42", k, b_addr, b_dout);
            end
         end
         if (k == 13) begin b_req = 1'b0; b_gwe = 1'b0; end
         tick();
      end
      $display("txn recover0 snes_read+gsu_write back_to_back");
   endtask

   initial begin
      test_reset();
      test_snes_read();
      repeat (2) tick();
      test_gsu_write();
      repeat (2) tick();
      test_priority();
      repeat (2) tick();
      test_overrun();
      repeat (2) tick();
      test_reset_mid();
      repeat (2) tick();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
